// File: rtl/uart_baud_ctrl.sv
// Baud-rate scheduler: 16x oversampling enable and per-bit TX tick from a programmable divisor.
// Divisor writes made while running are held in a shadow and applied only at a bit boundary.
module uart_baud_ctrl #(
   parameter int unsigned DIV_W     = 16,
   parameter int unsigned OVS       = 16,
   parameter int unsigned RESET_DIV = 0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             DIV_WR,
   input  logic [DIV_W-1:0] DIV_DATA,
   input  logic             SYNC,
   output logic             BAUD16,
   output logic             BAUDTX,
   output logic [DIV_W-1:0] DIV_CUR,
   output logic             PENDING
);

   localparam int unsigned OVS_W = (OVS > 1) ? $clog2(OVS) : 1;

   typedef enum logic {
      ST_STOP = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
   logic [OVS_W-1:0]   ovs_cnt_q, ovs_cnt_d;
   logic [DIV_W-1:0]   div_cur_q, div_cur_d;
   logic [DIV_W-1:0]   shadow_q, shadow_d;
   logic               pending_q, pending_d;
   logic               baud16_q, baud16_d;
   logic               baudtx_q, baudtx_d;
   logic               boundary;

   // State and datapath registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= ST_STOP;
         div_cnt_q <= '0;
         ovs_cnt_q <= '0;
         div_cur_q <= DIV_W'(RESET_DIV);
         shadow_q  <= '0;
         pending_q <= 1'b0;
         baud16_q  <= 1'b0;
         baudtx_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         ovs_cnt_q <= ovs_cnt_d;
         div_cur_q <= div_cur_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         baud16_q  <= baud16_d;
         baudtx_q  <= baudtx_d;
      end
   end

   // Next-state, counters and divisor sequencing
   always_comb begin
      state_d   = state_q;
      div_cnt_d = '0;
      ovs_cnt_d = '0;
      div_cur_d = div_cur_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      baud16_d  = 1'b0;
      baudtx_d  = 1'b0;
      boundary  = 1'b0;

      case (state_q)
         ST_STOP: begin
            pending_d = 1'b0;
            if (DIV_WR) begin
               div_cur_d = DIV_DATA;
            end
            if (EN && (div_cur_q != '0)) begin
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            if (!EN) begin
               // Leaving RUN flushes any pending divisor so software sees it in STOP
               if (DIV_WR) begin
                  div_cur_d = DIV_DATA;
               end else if (pending_q) begin
                  div_cur_d = shadow_q;
               end
               shadow_d  = '0;
               pending_d = 1'b0;
               state_d   = ST_STOP;
            end else begin
               if (SYNC) begin
                  boundary = 1'b1;
               end else if (div_cnt_q == (div_cur_q - DIV_W'(1))) begin
                  baud16_d = 1'b1;
                  if (ovs_cnt_q == OVS_W'(OVS - 1)) begin
                     baudtx_d = 1'b1;
                     boundary = 1'b1;
                  end else begin
                     ovs_cnt_d = ovs_cnt_q + OVS_W'(1);
                  end
               end else begin
                  div_cnt_d = div_cnt_q + DIV_W'(1);
                  ovs_cnt_d = ovs_cnt_q;
               end

               // A write landing on the boundary edge beats the shadow
               if (boundary) begin
                  if (DIV_WR) begin
                     div_cur_d = DIV_DATA;
                  end else if (pending_q) begin
                     div_cur_d = shadow_q;
                  end
                  shadow_d  = '0;
                  pending_d = 1'b0;
               end else if (DIV_WR) begin
                  shadow_d  = DIV_DATA;
                  pending_d = 1'b1;
               end

               if (div_cur_d == '0) begin
                  state_d = ST_STOP;
               end
            end
         end

         default: begin
            state_d = ST_STOP;
         end
      endcase
   end

   assign BAUD16  = baud16_q;
   assign BAUDTX  = baudtx_q;
   assign DIV_CUR = div_cur_q;
   assign PENDING = pending_q;

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Directed bench for uart_baud_ctrl: pulse timing, divisor sequencing, SYNC, STOP and reset behaviour.
module tb_uart_baud_ctrl;

   logic        CLK;
   logic        RST;
   logic        EN;
   logic        DIV_WR;
   logic [15:0] DIV_DATA;
   logic        SYNC;
   logic        BAUD16;
   logic        BAUDTX;
   logic [15:0] DIV_CUR;
   logic        PENDING;

   int n_checks = 0;
   int n_pass   = 0;

   uart_baud_ctrl #(
      .DIV_W    (16),
      .OVS      (16),
      .RESET_DIV(0)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .EN      (EN),
      .DIV_WR  (DIV_WR),
      .DIV_DATA(DIV_DATA),
      .SYNC    (SYNC),
      .BAUD16  (BAUD16),
      .BAUDTX  (BAUDTX),
      .DIV_CUR (DIV_CUR),
      .PENDING (PENDING)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge
   task automatic tick();
      @(negedge CLK);
   endtask

   // Ticks until the chosen pulse is seen; n = ticks taken, 0 on timeout
   task automatic wait_sig(input bit tx, input int max, output int n);
      n = 0;
      for (int i = 1; i <= max; i++) begin
         @(negedge CLK);
         if ((tx ? BAUDTX : BAUD16) === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic write_div(input logic [15:0] val);
      DIV_WR   = 1'b1;
      DIV_DATA = val;
      tick();
      DIV_WR   = 1'b0;
      DIV_DATA = '0;
   endtask

   int n;
   int b16_cnt, btx_cnt, first_b16, first_btx, b16_at_btx;

   initial begin
      RST      = 1'b1;
      EN       = 1'b0;
      DIV_WR   = 1'b0;
      DIV_DATA = '0;
      SYNC     = 1'b0;

      // Reset values
      tick();
      check("rst_baud16", 32'(BAUD16), 0);
      check("rst_baudtx", 32'(BAUDTX), 0);
      check("rst_div_cur", 32'(DIV_CUR), 0);
      check("rst_pending", 32'(PENDING), 0);

      RST = 1'b0;
      EN  = 1'b1;
      tick();
      tick();
      check("stop_div0_no_pulse", 32'(BAUD16), 0);

      // STOP write: one edge to DIV_CUR, then pulse timing at DIV=4
      write_div(16'd4);
      check("stop_wr_div_cur", 32'(DIV_CUR), 4);
      check("stop_wr_pending", 32'(PENDING), 0);
      b16_cnt = 0; btx_cnt = 0; first_b16 = 0; first_btx = 0; b16_at_btx = 0;
      for (int i = 1; i <= 70; i++) begin
         tick();
         if (BAUD16 === 1'b1) begin
            b16_cnt++;
            if (first_b16 == 0) first_b16 = i;
         end
         if (BAUDTX === 1'b1) begin
            btx_cnt++;
            if (first_btx == 0) first_btx = i;
            b16_at_btx = int'(BAUD16);
         end
      end
      check("first_b16_idx", 32'(first_b16), 5);
      check("b16_count", 32'(b16_cnt), 17);
      check("first_btx_idx", 32'(first_btx), 65);
      check("btx_count", 32'(btx_cnt), 1);
      check("btx_with_b16", 32'(b16_at_btx), 1);

      // Two writes mid-bit: last wins, applied at the BAUDTX edge
      write_div(16'd10);
      check("wr10_pending", 32'(PENDING), 1);
      check("wr10_div_cur", 32'(DIV_CUR), 4);
      write_div(16'd3);
      check("wr3_pending", 32'(PENDING), 1);
      wait_sig(1'b1, 100, n);
      check("boundary_wait", 32'(n), 57);
      check("boundary_div_cur", 32'(DIV_CUR), 3);
      check("boundary_pending", 32'(PENDING), 0);
      wait_sig(1'b0, 20, n);
      check("div3_next_b16", 32'(n), 3);

      // Write on the exact BAUDTX edge overrides the pending shadow
      write_div(16'd9);
      check("wr9_pending", 32'(PENDING), 1);
      check("wr9_div_cur", 32'(DIV_CUR), 3);
      repeat (43) tick();
      write_div(16'd7);
      check("edge_wr_btx", 32'(BAUDTX), 1);
      check("edge_wr_div_cur", 32'(DIV_CUR), 7);
      check("edge_wr_pending", 32'(PENDING), 0);
      wait_sig(1'b0, 20, n);
      check("div7_next_b16", 32'(n), 7);

      // SYNC applies a pending divisor, then SYNC at DIV=1 suppresses a pulse
      write_div(16'd1);
      check("wr1_pending", 32'(PENDING), 1);
      SYNC = 1'b1;
      tick();
      SYNC = 1'b0;
      check("sync_apply_div_cur", 32'(DIV_CUR), 1);
      check("sync_apply_pending", 32'(PENDING), 0);
      check("sync_apply_b16", 32'(BAUD16), 0);
      tick();
      check("div1_b16_a", 32'(BAUD16), 1);
      tick();
      SYNC = 1'b1;
      tick();
      SYNC = 1'b0;
      check("sync_suppress_b16", 32'(BAUD16), 0);
      check("sync_suppress_btx", 32'(BAUDTX), 0);
      tick();
      check("sync_resume_b16", 32'(BAUD16), 1);
      wait_sig(1'b1, 40, n);
      check("sync_btx_wait", 32'(n), 15);
      check("sync_btx_b16", 32'(BAUD16), 1);

      // Writing 0 while running: pulses continue until the boundary, then STOP
      write_div(16'd0);
      check("wr0_pending", 32'(PENDING), 1);
      check("wr0_still_b16", 32'(BAUD16), 1);
      wait_sig(1'b1, 40, n);
      check("wr0_boundary_wait", 32'(n), 15);
      check("wr0_div_cur", 32'(DIV_CUR), 0);
      check("wr0_last_b16", 32'(BAUD16), 1);
      SYNC = 1'b1;
      tick();
      SYNC = 1'b0;
      check("stopped_b16", 32'(BAUD16), 0);
      check("stopped_btx", 32'(BAUDTX), 0);
      b16_cnt = 0;
      repeat (5) begin
         tick();
         if (BAUD16 === 1'b1 || BAUDTX === 1'b1) b16_cnt++;
      end
      check("stopped_quiet", 32'(b16_cnt), 0);
      check("stopped_pending", 32'(PENDING), 0);

      // Asynchronous reset mid-count with a pulse and a pending write
      write_div(16'd5);
      check("div5_div_cur", 32'(DIV_CUR), 5);
      repeat (5) tick();
      write_div(16'd2);
      check("div5_b16", 32'(BAUD16), 1);
      check("div5_pending", 32'(PENDING), 1);
      #2 RST = 1'b1;
      #1;
      check("async_rst_b16", 32'(BAUD16), 0);
      check("async_rst_pending", 32'(PENDING), 0);
      check("async_rst_div_cur", 32'(DIV_CUR), 0);
      tick();
      RST = 1'b0;
      b16_cnt = 0;
      repeat (4) begin
         tick();
         if (BAUD16 === 1'b1 || BAUDTX === 1'b1) b16_cnt++;
      end
      check("rst_release_quiet", 32'(b16_cnt), 0);

      // EN drop with a pending write: STOP next edge and shadow lands in DIV_CUR
      EN = 1'b0;
      write_div(16'd6);
      check("div6_div_cur", 32'(DIV_CUR), 6);
      EN = 1'b1;
      tick();
      repeat (2) tick();
      write_div(16'd9);
      check("en_drop_pre_pending", 32'(PENDING), 1);
      check("en_drop_pre_div_cur", 32'(DIV_CUR), 6);
      repeat (2) tick();
      EN = 1'b0;
      tick();
      check("en_drop_b16", 32'(BAUD16), 0);
      check("en_drop_div_cur", 32'(DIV_CUR), 9);
      check("en_drop_pending", 32'(PENDING), 0);
      EN = 1'b1;
      wait_sig(1'b0, 20, n);
      check("div9_first_b16", 32'(n), 10);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
